// File: rtl/sdram_read.sv
// SDRAM read-burst engine: requests the bus, sweeps ROW_NUM rows of bank 0 in 4-beat READ bursts.
// Latency: command 1 cycle after decision; data valid CAS_LAT+1 cycles after READ on read_cmd.
// Backpressure: none on data; yields the bus to refresh at burst boundaries and resumes after re-grant.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   read_trig                   start pulse (IDLE only)
//   read_en                     arbiter grant (REQ only)
//   refresh_req                 refresh pending level
//   sdram_dq_in                 SDRAM data bus input
//   read_req                    bus request, high in REQ
//   read_end                    pulse on the final delivered beat
//   read_cmd, read_addr         registered {CS_n,RAS_n,CAS_n,WE_n} command and A[11:0]
//   bank_addr                   always bank 0
//   rd_data, rd_data_vld        captured read word and its qualifier
module sdram_read #(
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int ROW_NUM = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        read_trig,
  input  logic        read_en,
  input  logic        refresh_req,
  input  logic [15:0] sdram_dq_in,
  output logic        read_req,
  output logic        read_end,
  output logic [3:0]  read_cmd,
  output logic [11:0] read_addr,
  output logic [1:0]  bank_addr,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  localparam logic [11:0] LAST_ROW = 12'(ROW_NUM - 1);
  localparam logic [8:0]  LAST_COL = 9'd508;
  localparam logic [7:0]  RCD_LAST = 8'(T_RCD - 1);
  localparam logic [7:0]  RP_LAST  = 8'(T_RP - 1);

  logic [2:0]       state_q, state_d;
  logic [11:0]      row_q, row_d;
  logic [8:0]       col_q, col_d;
  logic [1:0]       burst_q, burst_d;
  logic [7:0]       tmr_q, tmr_d;
  logic             done_q, done_d;
  logic             row_chg_q, row_chg_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [11:0]      addr_q, addr_d;
  logic [CAS_LAT:0] vpipe_q, vpipe_d;   // beat-valid shift, tap at CAS_LAT
  logic [CAS_LAT:0] epipe_q, epipe_d;   // marks the final beat of the final burst
  logic [15:0]      dat_q, dat_d;
  logic             vld_q, vld_d;
  logic             end_q, end_d;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    burst_d   = burst_q;
    tmr_d     = tmr_q;
    done_d    = done_q;
    row_chg_d = row_chg_q;
    cmd_d     = CMD_NOP;
    addr_d    = addr_q;

    // The capture pipe runs in every state so beats in flight drain through PRE.
    vpipe_d = {vpipe_q[CAS_LAT-1:0], 1'b0};
    epipe_d = {epipe_q[CAS_LAT-1:0], 1'b0};
    vld_d   = vpipe_q[CAS_LAT];
    end_d   = epipe_q[CAS_LAT];
    dat_d   = vpipe_q[CAS_LAT] ? sdram_dq_in : dat_q;

    case (state_q)
      S_IDLE: begin
        if (read_trig) begin
          state_d   = S_REQ;
          row_d     = '0;
          col_d     = '0;
          done_d    = 1'b0;
          row_chg_d = 1'b0;
        end
      end
      S_REQ: begin
        if (read_en) begin
          state_d   = S_ACT;
          tmr_d     = '0;
          row_chg_d = 1'b0;
        end
      end
      S_ACT: begin
        if (tmr_q == 8'd0) begin
          cmd_d  = CMD_ACT;
          addr_d = row_q;
        end
        if (tmr_q == RCD_LAST) begin
          state_d = S_RD;
          tmr_d   = '0;
          burst_d = '0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_RD: begin
        vpipe_d[0] = 1'b1;
        burst_d    = burst_q + 2'd1;
        if (burst_q == 2'd0) begin
          cmd_d  = CMD_READ;
          addr_d = {3'b000, col_q};
        end
        // Exit decisions only at the burst boundary, so a burst always completes.
        if (burst_q == 2'd3) begin
          col_d = col_q + 9'd4;
          tmr_d = '0;
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d    = S_PRE;
            done_d     = 1'b1;
            epipe_d[0] = 1'b1;
          end else if (col_q == LAST_COL) begin
            state_d   = S_PRE;
            row_d     = row_q + 12'd1;
            row_chg_d = 1'b1;
          end else if (refresh_req) begin
            state_d = S_PRE;
          end
        end
      end
      S_PRE: begin
        if (tmr_q == 8'd0) begin
          cmd_d  = CMD_PRE;
          addr_d = 12'h400;
        end
        if (tmr_q != RP_LAST) begin
          tmr_d = tmr_q + 8'd1;
        end else if (done_q) begin
          // Finished: hold in PRE until the last beat has left the pipe.
          if (vpipe_q == '0) begin
            state_d = S_IDLE;
          end
        end else if (refresh_req) begin
          state_d = S_REQ;
        end else if (row_chg_q) begin
          state_d   = S_ACT;
          tmr_d     = '0;
          row_chg_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      burst_q   <= '0;
      tmr_q     <= '0;
      done_q    <= 1'b0;
      row_chg_q <= 1'b0;
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      vpipe_q   <= '0;
      epipe_q   <= '0;
      dat_q     <= '0;
      vld_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      burst_q   <= burst_d;
      tmr_q     <= tmr_d;
      done_q    <= done_d;
      row_chg_q <= row_chg_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      vpipe_q   <= vpipe_d;
      epipe_q   <= epipe_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      end_q     <= end_d;
    end
  end

  assign read_req    = (state_q == S_REQ);
  assign read_end    = end_q;
  assign read_cmd    = cmd_q;
  assign read_addr   = addr_q;
  assign bank_addr   = 2'b00;
  assign rd_data     = dat_q;
  assign rd_data_vld = vld_q;

endmodule

// File: tb/tb_sdram_read.sv
module tb_sdram_read;

  localparam int CAS = 3;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_PRE = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        read_trig = 1'b0;
  logic        read_en = 1'b0;
  logic        refresh_req = 1'b0;
  logic [15:0] sdram_dq_in = '0;
  logic        read_req, read_end, rd_data_vld;
  logic [3:0]  read_cmd;
  logic [11:0] read_addr;
  logic [1:0]  bank_addr;
  logic [15:0] rd_data;

  int checks = 0;
  int failures = 0;

  sdram_read #(.CAS_LAT(3), .T_RCD(2), .T_RP(2), .ROW_NUM(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .read_trig(read_trig),
    .read_en(read_en), .refresh_req(refresh_req), .sdram_dq_in(sdram_dq_in),
    .read_req(read_req), .read_end(read_end), .read_cmd(read_cmd),
    .read_addr(read_addr), .bank_addr(bank_addr), .rd_data(rd_data),
    .rd_data_vld(rd_data_vld)
  );

  initial forever #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Memory contents: each (row, col) holds a distinct word.
  function automatic logic [15:0] exp_word(input logic [11:0] r, input logic [8:0] c);
    return {r[6:0], c} ^ 16'hA5C3;
  endfunction

  // SDRAM model: commands seen in cycle t schedule dq for cycles t+CAS .. t+CAS+3.
  int          cyc = 0;
  logic [15:0] sched_dat [16];
  int          sched_cyc [16] = '{default: -1};
  logic [11:0] cur_row = '0;

  initial forever begin
    @(posedge sys_clk);
    cyc = cyc + 1;
    #1;
    if (sched_cyc[cyc % 16] == cyc) sdram_dq_in = sched_dat[cyc % 16];
    else                            sdram_dq_in = 16'($urandom);
  end

  // Stream bookkeeping: expected sweep order row-major, counters read by the tests.
  int   beat_cnt = 0, exp_idx = 0, data_err = 0, gap_cnt = 0;
  int   end_cnt = 0, end_beat = 0, end_err = 0;
  logic prev_vld = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    if (read_cmd == C_ACT) cur_row = read_addr;
    if (read_cmd == C_RD) begin
      for (int i = 0; i < 4; i++) begin
        sched_dat[(cyc + CAS + i) % 16] = exp_word(cur_row, read_addr[8:0] + 9'(i));
        sched_cyc[(cyc + CAS + i) % 16] = cyc + CAS + i;
      end
    end
    if (!sys_rst_n) begin
      exp_idx  = 0;
      beat_cnt = 0;
      prev_vld = 1'b0;
    end else begin
      if (rd_data_vld) begin
        if (rd_data !== exp_word(12'(exp_idx / 512), 9'(exp_idx % 512))) data_err++;
        if (!prev_vld && (exp_idx % 512) != 0) gap_cnt++;
        beat_cnt++;
        exp_idx++;
        if (read_end) begin
          end_cnt++;
          end_beat = beat_cnt;
          exp_idx  = 0;
        end
      end else if (read_end) begin
        end_err++;
      end
      prev_vld = rd_data_vld;
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      read_trig   = 1'($urandom);
      read_en     = 1'($urandom);
      refresh_req = 1'($urandom);
      tick();
    end
    @(negedge sys_clk);
    checks++; if (read_cmd !== C_NOP) begin failures++; $display("FAIL reset_cmd got=%b exp=%b", read_cmd, C_NOP); end
    checks++; if (read_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", read_addr); end
    checks++; if (read_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", read_req); end
    checks++; if (rd_data_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", rd_data_vld); end
    checks++; if (read_end !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", read_end); end
    checks++; if (rd_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", rd_data); end
    checks++; if (bank_addr !== 2'b00) begin failures++; $display("FAIL reset_bank got=%b exp=00", bank_addr); end
    read_trig = 1'b0; read_en = 1'b0; refresh_req = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic_burst;
    logic [3:0]  c_cmd [16];
    logic [11:0] c_addr [16];
    logic        c_vld [16];
    logic        c_req [16];
    logic [15:0] c_dat [16];
    read_trig = 1'b1;
    tick();
    read_trig = 1'b0;
    @(negedge sys_clk);
    checks++; if (read_req !== 1'b1) begin failures++; $display("FAIL basic_req_first got=%b exp=1", read_req); end
    tick();
    tick();
    read_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      c_cmd[i] = read_cmd; c_addr[i] = read_addr; c_vld[i] = rd_data_vld;
      c_req[i] = read_req; c_dat[i] = rd_data;
      tick();
      if (i == 0) read_en = 1'b0;
    end
    checks++; if (c_req[1] !== 1'b0) begin failures++; $display("FAIL basic_req_drop got=%b exp=0", c_req[1]); end
    checks++; if (c_cmd[1] !== C_NOP) begin failures++; $display("FAIL basic_pre_act got=%b exp=%b", c_cmd[1], C_NOP); end
    checks++; if (c_cmd[2] !== C_ACT || c_addr[2] !== 12'd0) begin failures++; $display("FAIL basic_act got=%b/%h exp=%b/000", c_cmd[2], c_addr[2], C_ACT); end
    checks++; if (c_cmd[3] !== C_NOP) begin failures++; $display("FAIL basic_rcd_nop got=%b exp=%b", c_cmd[3], C_NOP); end
    checks++; if (c_cmd[4] !== C_RD || c_addr[4] !== 12'd0) begin failures++; $display("FAIL basic_read0 got=%b/%h exp=%b/000", c_cmd[4], c_addr[4], C_RD); end
    checks++; if (c_cmd[8] !== C_RD || c_addr[8] !== 12'd4) begin failures++; $display("FAIL basic_read4 got=%b/%h exp=%b/004", c_cmd[8], c_addr[8], C_RD); end
    checks++; if (c_cmd[12] !== C_RD || c_addr[12] !== 12'd8) begin failures++; $display("FAIL basic_read8 got=%b/%h exp=%b/008", c_cmd[12], c_addr[12], C_RD); end
    checks++; if (c_vld[7] !== 1'b0) begin failures++; $display("FAIL basic_vld_early got=%b exp=0", c_vld[7]); end
    checks++; if (c_vld[8] !== 1'b1 || c_dat[8] !== exp_word(12'd0, 9'd0)) begin failures++; $display("FAIL basic_beat0 got=%b/%h exp=1/%h", c_vld[8], c_dat[8], exp_word(12'd0, 9'd0)); end
    checks++; if (c_vld[11] !== 1'b1 || c_dat[11] !== exp_word(12'd0, 9'd3)) begin failures++; $display("FAIL basic_beat3 got=%b/%h exp=1/%h", c_vld[11], c_dat[11], exp_word(12'd0, 9'd3)); end
    checks++; if (c_vld[12] !== 1'b1 || c_dat[12] !== exp_word(12'd0, 9'd4)) begin failures++; $display("FAIL basic_beat4 got=%b/%h exp=1/%h", c_vld[12], c_dat[12], exp_word(12'd0, 9'd4)); end
    checks++; if (c_vld[15] !== 1'b1 || c_dat[15] !== exp_word(12'd0, 9'd7)) begin failures++; $display("FAIL basic_beat7 got=%b/%h exp=1/%h", c_vld[15], c_dat[15], exp_word(12'd0, 9'd7)); end
  endtask

  task automatic test_refresh;
    logic [3:0]  c_cmd [8];
    logic [11:0] c_addr [8];
    logic        c_vld [8];
    logic        c_req [8];
    logic [3:0]  g_cmd [6];
    logic [11:0] g_addr [6];
    int          bc;
    bit          found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge sys_clk);
      if (read_cmd == C_RD && read_addr == 12'd96) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL refresh_find96 got=timeout exp=READ col 96"); end
    if (found) begin
      repeat (4) tick();
      refresh_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge sys_clk);
        c_cmd[i] = read_cmd; c_addr[i] = read_addr; c_vld[i] = rd_data_vld; c_req[i] = read_req;
        tick();
      end
      refresh_req = 1'b0;
      read_en = 1'b1;
      bc = -1;
      for (int j = 0; j < 6; j++) begin
        @(negedge sys_clk);
        g_cmd[j] = read_cmd; g_addr[j] = read_addr;
        tick();
        if (j == 0) read_en = 1'b0;
        if (j == 2) bc = beat_cnt;
      end
      checks++; if (c_cmd[0] !== C_RD || c_addr[0] !== 12'd100) begin failures++; $display("FAIL refresh_read100 got=%b/%h exp=%b/064", c_cmd[0], c_addr[0], C_RD); end
      checks++; if (c_cmd[1] !== C_NOP || c_cmd[2] !== C_NOP || c_cmd[3] !== C_NOP) begin failures++; $display("FAIL refresh_burst_nop got=%b %b %b exp=%b", c_cmd[1], c_cmd[2], c_cmd[3], C_NOP); end
      checks++; if (c_cmd[4] !== C_PRE || c_addr[4] !== 12'h400) begin failures++; $display("FAIL refresh_pre got=%b/%h exp=%b/400", c_cmd[4], c_addr[4], C_PRE); end
      checks++; if (c_vld[4] !== 1'b1 || c_vld[5] !== 1'b1 || c_vld[6] !== 1'b1 || c_vld[7] !== 1'b1) begin failures++; $display("FAIL refresh_beats got=%b%b%b%b exp=1111", c_vld[4], c_vld[5], c_vld[6], c_vld[7]); end
      checks++; if (c_req[4] !== 1'b0 || c_req[5] !== 1'b1) begin failures++; $display("FAIL refresh_req got=%b%b exp=01", c_req[4], c_req[5]); end
      checks++; if (g_cmd[2] !== C_ACT || g_addr[2] !== 12'd0) begin failures++; $display("FAIL refresh_act got=%b/%h exp=%b/000", g_cmd[2], g_addr[2], C_ACT); end
      checks++; if (g_cmd[4] !== C_RD || g_addr[4] !== 12'd104) begin failures++; $display("FAIL refresh_resume got=%b/%h exp=%b/068", g_cmd[4], g_addr[4], C_RD); end
      checks++; if (bc !== 104) begin failures++; $display("FAIL refresh_beatcnt got=%0d exp=104", bc); end
    end
  endtask

  task automatic test_row_change;
    logic [3:0]  c_cmd [9];
    logic [11:0] c_addr [9];
    logic        c_vld [9];
    int          nv;
    bit          found;
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge sys_clk);
      if (read_cmd == C_RD && read_addr == 12'd508) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL row_find508 got=timeout exp=READ col 508"); end
    if (found) begin
      c_cmd[0] = read_cmd; c_addr[0] = read_addr; c_vld[0] = rd_data_vld;
      for (int i = 1; i < 9; i++) begin
        tick();
        @(negedge sys_clk);
        c_cmd[i] = read_cmd; c_addr[i] = read_addr; c_vld[i] = rd_data_vld;
      end
      nv = 0;
      for (int i = 0; i < 8; i++) nv += int'(c_vld[i]);
      checks++; if (c_cmd[4] !== C_PRE || c_addr[4] !== 12'h400) begin failures++; $display("FAIL row_pre got=%b/%h exp=%b/400", c_cmd[4], c_addr[4], C_PRE); end
      checks++; if (c_cmd[5] !== C_NOP) begin failures++; $display("FAIL row_rp_nop got=%b exp=%b", c_cmd[5], C_NOP); end
      checks++; if (c_cmd[6] !== C_ACT || c_addr[6] !== 12'd1) begin failures++; $display("FAIL row_act got=%b/%h exp=%b/001", c_cmd[6], c_addr[6], C_ACT); end
      checks++; if (c_cmd[8] !== C_RD || c_addr[8] !== 12'd0) begin failures++; $display("FAIL row_read0 got=%b/%h exp=%b/000", c_cmd[8], c_addr[8], C_RD); end
      checks++; if (nv !== 8 || c_vld[8] !== 1'b0) begin failures++; $display("FAIL row_vld got=%0d/%b exp=8/0", nv, c_vld[8]); end
      tick();
    end
  endtask

  task automatic test_completion;
    bit found;
    int busy;
    read_trig = 1'b1;
    tick();
    read_trig = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 800 && !found; n++) begin
      @(negedge sys_clk);
      if (read_end === 1'b1) found = 1'b1;
      tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL done_end_seen got=timeout exp=read_end pulse"); end
    checks++; if (beat_cnt !== 1024) begin failures++; $display("FAIL done_beats got=%0d exp=1024", beat_cnt); end
    checks++; if (end_cnt !== 1) begin failures++; $display("FAIL done_end_count got=%0d exp=1", end_cnt); end
    checks++; if (end_beat !== 1024 || end_err !== 0) begin failures++; $display("FAIL done_end_align got=%0d/%0d exp=1024/0", end_beat, end_err); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL done_data got=%0d exp=0", data_err); end
    checks++; if (gap_cnt !== 1) begin failures++; $display("FAIL done_gaps got=%0d exp=1", gap_cnt); end
    busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (read_req !== 1'b0 || rd_data_vld !== 1'b0 || read_end !== 1'b0 || (i > 0 && read_cmd !== C_NOP)) busy++;
      tick();
    end
    checks++; if (busy !== 0) begin failures++; $display("FAIL done_quiet got=%0d exp=0", busy); end
    read_trig = 1'b1;
    tick();
    read_trig = 1'b0;
    @(negedge sys_clk);
    checks++; if (read_req !== 1'b1) begin failures++; $display("FAIL done_idle_retrig got=%b exp=1", read_req); end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [3:0]  c_cmd [10];
    logic [11:0] c_addr [10];
    logic        c_vld [10];
    logic [15:0] c_dat [10];
    int          nv;
    bit          found;
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge sys_clk);
      if (read_cmd == C_RD && read_addr == 12'd8) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL rstmid_find8 got=timeout exp=READ col 8"); end
    tick();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    checks++; if (read_cmd !== C_NOP || read_addr !== 12'd0) begin failures++; $display("FAIL rstmid_cmd got=%b/%h exp=%b/000", read_cmd, read_addr, C_NOP); end
    checks++; if (rd_data_vld !== 1'b0 || read_end !== 1'b0 || read_req !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b%b exp=000", rd_data_vld, read_end, read_req); end
    checks++; if (rd_data !== 16'h0000) begin failures++; $display("FAIL rstmid_data got=%h exp=0000", rd_data); end
    tick();
    tick();
    sys_rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      nv += int'(rd_data_vld);
      tick();
    end
    checks++; if (nv !== 0 || beat_cnt !== 0) begin failures++; $display("FAIL rstmid_no_beats got=%0d/%0d exp=0/0", nv, beat_cnt); end
    read_trig = 1'b1;
    tick();
    read_trig = 1'b0;
    tick();
    read_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      c_cmd[i] = read_cmd; c_addr[i] = read_addr; c_vld[i] = rd_data_vld; c_dat[i] = rd_data;
      tick();
      if (i == 0) read_en = 1'b0;
    end
    checks++; if (c_cmd[2] !== C_ACT || c_addr[2] !== 12'd0) begin failures++; $display("FAIL rstmid_act got=%b/%h exp=%b/000", c_cmd[2], c_addr[2], C_ACT); end
    checks++; if (c_cmd[4] !== C_RD || c_addr[4] !== 12'd0) begin failures++; $display("FAIL rstmid_read got=%b/%h exp=%b/000", c_cmd[4], c_addr[4], C_RD); end
    checks++; if (c_vld[8] !== 1'b1 || c_dat[8] !== exp_word(12'd0, 9'd0)) begin failures++; $display("FAIL rstmid_beat0 got=%b/%h exp=1/%h", c_vld[8], c_dat[8], exp_word(12'd0, 9'd0)); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL rstmid_data got=%0d exp=0", data_err); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_refresh();
    test_row_change();
    test_completion();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
